// File: rtl/spart_rx.sv
// SPART receiver: synchronises RxD, oversamples it on the baud enable tick,
// deserialises 8N1 frames LSB first and holds the last good byte for the bus.
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       RxD,
  input  logic       IOCS,
  input  logic       IORW,
  input  logic [1:0] IOADDR,
  output logic [7:0] R_BUFFER,
  output logic       RDA,
  output logic       FRAMING_ERR,
  output logic       OVERRUN
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    samp_cnt, samp_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shift_reg, shift_n;
  logic [7:0]       rbuf_n;
  logic             rda_n, fe_n, ovr_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rxs;
  logic             rd_strobe;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign rd_strobe = IOCS & IORW & (IOADDR == 2'b00);

  // Metastability synchroniser for the asynchronous serial input (idles high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
  end

  // State, counters, shift register and bus-visible flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      R_BUFFER    <= '0;
      RDA         <= 1'b0;
      FRAMING_ERR <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      state       <= state_n;
      samp_cnt    <= samp_n;
      bit_cnt     <= bit_n;
      shift_reg   <= shift_n;
      R_BUFFER    <= rbuf_n;
      RDA         <= rda_n;
      FRAMING_ERR <= fe_n;
      OVERRUN     <= ovr_n;
    end
  end

  // Next-state logic; a read clears the flags first so a same-cycle
  // load or framing error below takes precedence over the clear.
  always_comb begin
    state_n = state;
    samp_n  = samp_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    rbuf_n  = R_BUFFER;
    rda_n   = RDA;
    fe_n    = FRAMING_ERR;
    ovr_n   = OVERRUN;

    if (rd_strobe) begin
      rda_n = 1'b0;
      fe_n  = 1'b0;
      ovr_n = 1'b0;
    end

    if (enable) begin
      unique case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state_n = ST_START;
            samp_n  = '0;
          end
        end
        ST_START: begin
          if (samp_cnt == HALF_LAST) begin
            samp_n = '0;
            if (!rxs) begin
              state_n = ST_DATA;
              bit_n   = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            samp_n = samp_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (samp_cnt == BIT_LAST) begin
            shift_n = {rxs, shift_reg[7:1]};
            samp_n  = '0;
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = ST_STOP;
          end else begin
            samp_n = samp_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (samp_cnt == BIT_LAST) begin
            samp_n = '0;
            if (rxs) begin
              rbuf_n  = shift_reg;
              rda_n   = 1'b1;
              fe_n    = 1'b0;
              if (RDA && !rd_strobe) ovr_n = 1'b1;
              state_n = ST_IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            samp_n = samp_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: drives 8N1 frames tick by tick and compares the bus
// outputs against a frame-level model of the receive buffer and flags.
module tb_spart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       RxD;
  logic       IOCS;
  logic       IORW;
  logic [1:0] IOADDR;
  logic [7:0] R_BUFFER;
  logic       RDA;
  logic       FRAMING_ERR;
  logic       OVERRUN;

  int unsigned div;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model: buffer and flags as seen by the bus
  logic [7:0] m_buf;
  logic       m_rda, m_fe, m_ovr;

  logic [10:0] obs;
  assign obs = {R_BUFFER, RDA, FRAMING_ERR, OVERRUN};

  spart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .RxD(RxD),
    .IOCS(IOCS), .IORW(IORW), .IOADDR(IOADDR),
    .R_BUFFER(R_BUFFER), .RDA(RDA), .FRAMING_ERR(FRAMING_ERR), .OVERRUN(OVERRUN)
  );

  always #5 clk = ~clk;

  // Line level at tick t of a frame: start, 8 data LSB first, stop, then idle
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int t);
    logic [7:0] sh;
    if (t < OS) return 1'b0;
    if (t < 9 * OS) begin
      sh = d >> (t / OS - 1);
      return sh[0];
    end
    if (t < 10 * OS) return stop;
    return 1'b1;
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_buf, m_rda, m_fe, m_ovr};
  endfunction

  task automatic model_reset();
    m_buf = '0; m_rda = 0; m_fe = 0; m_ovr = 0;
  endtask

  task automatic model_load(input logic [7:0] d, input logic rd_same);
    if (rd_same)    m_ovr = 1'b0;
    else if (m_rda) m_ovr = 1'b1;
    m_rda = 1'b1;
    m_buf = d;
    m_fe  = 1'b0;
  endtask

  task automatic model_ferr(input logic rd_same);
    m_fe = 1'b1;
    if (rd_same) begin m_rda = 1'b0; m_ovr = 1'b0; end
  endtask

  // One enable tick period of div clocks; called and returning at a negedge
  task automatic tick(input logic v, input logic rd);
    RxD = v; enable = 1'b1;
    IOCS = rd; IORW = rd; IOADDR = 2'b00;
    @(negedge clk);
    enable = 1'b0; IOCS = 1'b0; IORW = 1'b0;
    repeat (div - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int low_after, input int rd_tick);
    for (int t = 0; t < 10 * OS; t++) tick(frame_bit(d, stop, t), t == rd_tick);
    for (int t = 0; t < low_after; t++) tick(1'b0, 1'b0);
    for (int t = 0; t < 8; t++) tick(1'b1, 1'b0);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic rw);
    IOCS = 1'b1; IORW = rw; IOADDR = addr;
    @(negedge clk);
    IOCS = 1'b0; IORW = 1'b0; IOADDR = 2'b00;
    if (rw && addr == 2'b00) begin m_rda = 0; m_ovr = 0; m_fe = 0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL reset_held: got %h expected %h", obs, model_vec());
    else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL reset_release: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_frame_55();
    div = 4;
    for (int t = 0; t < 10 * OS + 8; t++) begin
      tick(frame_bit(8'h55, 1'b1, t), 1'b0);
      if (t == 152) begin
        n_checks++;
        if (RDA !== 1'b0) $display("FAIL rda_early: got %b expected 0", RDA);
        else n_pass++;
      end
      if (t == 153) begin
        n_checks++;
        if ({RDA, R_BUFFER} !== {1'b1, 8'h55})
          $display("FAIL rda_mid_stop: got %b/%h expected 1/55", RDA, R_BUFFER);
        else n_pass++;
      end
    end
    model_load(8'h55, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL frame_55: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_read();
    do_read(2'b01, 1'b1);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL read_addr01: got %h expected %h", obs, model_vec());
    else n_pass++;
    do_read(2'b00, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL write_addr00: got %h expected %h", obs, model_vec());
    else n_pass++;
    do_read(2'b00, 1'b1);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL read_addr00: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_glitch();
    div = 4;
    for (int t = 0; t < 4; t++) tick(1'b0, 1'b0);
    for (int t = 0; t < 24; t++) tick(1'b1, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL glitch: got %h expected %h", obs, model_vec());
    else n_pass++;
    send_frame(8'hA3, 1'b1, 0, -1);
    model_load(8'hA3, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL after_glitch_a3: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_framing();
    div = 4;
    do_read(2'b00, 1'b1);
    for (int t = 0; t < 10 * OS + 3 * OS; t++) tick(t < 10 * OS ? frame_bit(8'h3C, 1'b0, t) : 1'b0, 1'b0);
    model_ferr(1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL break_low: got %h expected %h", obs, model_vec());
    else n_pass++;
    for (int t = 0; t < 4 * OS; t++) tick(1'b1, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL break_release: got %h expected %h", obs, model_vec());
    else n_pass++;
    do_read(2'b00, 1'b1);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL ferr_cleared: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    div = 4;
    send_frame(8'h11, 1'b1, 0, -1);
    model_load(8'h11, 1'b0);
    send_frame(8'h22, 1'b1, 0, -1);
    model_load(8'h22, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL overrun: got %h expected %h", obs, model_vec());
    else n_pass++;
    do_read(2'b00, 1'b1);
    send_frame(8'h33, 1'b1, 0, -1);
    model_load(8'h33, 1'b0);
    send_frame(8'h44, 1'b1, 0, 153);
    model_load(8'h44, 1'b1);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL load_vs_read: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    div = 4;
    for (int t = 0; t <= 88; t++) tick(frame_bit(8'hFF, 1'b1, t), 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs !== model_vec()) $display("FAIL async_reset: got %h expected %h", obs, model_vec());
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 89; t < 10 * OS + 8; t++) tick(frame_bit(8'hFF, 1'b1, t), 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL partial_discarded: got %h expected %h", obs, model_vec());
    else n_pass++;
    send_frame(8'h81, 1'b1, 0, -1);
    model_load(8'h81, 1'b0);
    n_checks++;
    if (obs !== model_vec()) $display("FAIL after_reset_81: got %h expected %h", obs, model_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    for (int i = 0; i < 12; i++) begin
      div  = $urandom_range(1, 4);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, stop, 0, -1);
      if (stop) model_load(d, 1'b0);
      else      model_ferr(1'b0);
      n_checks++;
      if (obs !== model_vec())
        $display("FAIL random_frame%0d div%0d: got %h expected %h", i, div, obs, model_vec());
      else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        do_read(2'b00, 1'b1);
        n_checks++;
        if (obs !== model_vec())
          $display("FAIL random_read%0d: got %h expected %h", i, obs, model_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; RxD = 1'b1;
    IOCS = 1'b0; IORW = 1'b0; IOADDR = 2'b00;
    div = 4;
    test_reset();
    test_frame_55();
    test_read();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
